// File: rtl/sync_down_counter_if.sv
// sync_down_counter_if: control and status bundle of the down counter/timer
interface sync_down_counter_if #(parameter int WIDTH = 4);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             zero;
  logic             tc;
  logic             busy;
  modport master (output en, load, load_val, input count, zero, tc, busy);
  modport slave  (input en, load, load_val, output count, zero, tc, busy);
endinterface

// File: rtl/sync_down_counter.sv
// sync_down_counter: wrap-down free run, loadable one-shot or auto-reload countdown with registered tc
module sync_down_counter #(
  parameter int WIDTH       = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input logic                clk,
  input logic                rst,
  sync_down_counter_if.slave bus
);
  typedef enum logic [1:0] {FREE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, rel_q, rel_d;
  logic             tc_q, tc_d;
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rel_d   = rel_q;
    tc_d    = 1'b0;
    if (bus.load) begin
      count_d = bus.load_val;
      rel_d   = bus.load_val;
      state_d = (bus.load_val != '0) ? RUN : DONE;
    end else if (bus.en && state_q == FREE) begin
      count_d = count_q - 1'b1;
    end else if (bus.en && state_q == RUN) begin
      // count 0 in RUN only happens with auto-reload, one cycle after tc
      count_d = (count_q == '0) ? rel_q : count_q - 1'b1;
      tc_d    = (count_q == WIDTH'(1));
      state_d = (count_q == WIDTH'(1) && !AUTO_RELOAD) ? DONE : RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FREE;
      count_q <= '1;
      rel_q   <= '1;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rel_q   <= rel_d;
      tc_q    <= tc_d;
    end
  end
  assign bus.count = count_q;
  assign bus.zero  = (count_q == '0);
  assign bus.tc    = tc_q;
  assign bus.busy  = (state_q == RUN);
endmodule

// File: tb/tb_sync_down_counter.sv
// tb_sync_down_counter: one-shot and auto-reload instances driven in lockstep against a behavioural model
module tb_sync_down_counter;
  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, ld = 1'b0;
  logic [3:0] lv = '0;
  int total = 0, bad = 0;
  bit chk_on = 1'b0;
  int m_cnt [2];
  int m_rel [2];
  int m_mode [2];
  int m_tc [2];
  always #5 clk = ~clk;
  sync_down_counter_if #(.WIDTH(4)) b0 ();
  sync_down_counter_if #(.WIDTH(4)) b1 ();
  assign b0.en = en;
  assign b0.load = ld;
  assign b0.load_val = lv;
  assign b1.en = en;
  assign b1.load = ld;
  assign b1.load_val = lv;
  sync_down_counter #(.WIDTH(4), .AUTO_RELOAD(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  sync_down_counter #(.WIDTH(4), .AUTO_RELOAD(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // mode: 0 free-running, 1 counting down after a load, 2 finished one-shot
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_cnt[k] = 15; m_rel[k] = 15; m_mode[k] = 0; m_tc[k] = 0;
      end else if (ld) begin
        m_cnt[k] = int'(lv); m_rel[k] = int'(lv); m_mode[k] = (lv != 0) ? 1 : 2; m_tc[k] = 0;
      end else begin
        m_tc[k] = 0;
        if (en && m_mode[k] == 0) m_cnt[k] = (m_cnt[k] + 15) % 16;
        else if (en && m_mode[k] == 1) begin
          if (m_cnt[k] == 1) begin
            m_cnt[k] = 0; m_tc[k] = 1;
            if (k == 0) m_mode[k] = 2;
          end else if (m_cnt[k] == 0) m_cnt[k] = m_rel[k];
          else m_cnt[k] = m_cnt[k] - 1;
        end
      end
    end
  end
  always @(negedge clk) begin
    if (chk_on) begin
      chk("m0_count", int'(b0.count), m_cnt[0]);
      chk("m0_zero", int'(b0.zero), int'(m_cnt[0] == 0));
      chk("m0_tc", int'(b0.tc), m_tc[0]);
      chk("m0_busy", int'(b0.busy), int'(m_mode[0] == 1));
      chk("m1_count", int'(b1.count), m_cnt[1]);
      chk("m1_zero", int'(b1.zero), int'(m_cnt[1] == 0));
      chk("m1_tc", int'(b1.tc), m_tc[1]);
      chk("m1_busy", int'(b1.busy), int'(m_mode[1] == 1));
    end
  end
  task automatic cyc(input logic r, input logic e, input logic l, input logic [3:0] v);
    rst = r; en = e; ld = l; lv = v;
    @(posedge clk);
    #1;
  endtask
  initial begin
    cyc(1, 0, 0, 0);
    chk_on = 1'b1;
    chk("rst_count", int'(b0.count), 15);
    chk("rst_zero", int'(b0.zero), 0);
    chk("rst_busy", int'(b0.busy), 0);
    chk("rst_tc", int'(b0.tc), 0);
    for (int i = 1; i <= 17; i++) begin
      cyc(0, 1, 0, 0);
      if (i == 15) chk("free_at0", int'(b0.count), 0);
      if (i == 15) chk("free_zero", int'(b0.zero), 1);
    end
    chk("free_wrap", int'(b0.count), 14);
    chk("free_tc", int'(b0.tc), 0);
    cyc(0, 0, 1, 3);
    chk("os_load", int'(b0.count), 3);
    chk("os_busy", int'(b0.busy), 1);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("os_tc_early", int'(b0.tc), 0);
    cyc(0, 1, 0, 0);
    chk("os_count0", int'(b0.count), 0);
    chk("os_tc", int'(b0.tc), 1);
    chk("os_done_busy", int'(b0.busy), 0);
    chk("ar_tc", int'(b1.tc), 1);
    chk("ar_busy", int'(b1.busy), 1);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0);
    chk("os_hold", int'(b0.count), 0);
    chk("os_hold_tc", int'(b0.tc), 0);
    chk("ar_reload3", int'(b1.count), 3);
    cyc(0, 0, 1, 2);
    for (int i = 1; i <= 8; i++) cyc(0, 1, 0, 0);
    chk("ar_c8", int'(b1.count), 0);
    chk("ar_tc8", int'(b1.tc), 1);
    cyc(0, 1, 0, 0);
    chk("ar_c9", int'(b1.count), 2);
    chk("ar_tc9", int'(b1.tc), 0);
    chk("os_c9", int'(b0.count), 0);
    cyc(0, 0, 1, 5);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("gate_hold", int'(b0.count), 4);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("gate_count", int'(b0.count), 2);
    cyc(0, 0, 1, 0);
    chk("ld0_zero", int'(b0.zero), 1);
    chk("ld0_busy", int'(b1.busy), 0);
    chk("ld0_tc", int'(b1.tc), 0);
    cyc(0, 1, 1, 7);
    chk("ld_en_ign", int'(b0.count), 7);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0);
    chk("pre_coll", int'(b0.count), 1);
    cyc(0, 1, 1, 4);
    chk("coll_count", int'(b0.count), 4);
    chk("coll_tc", int'(b0.tc), 0);
    cyc(0, 0, 1, 9);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
    chk("mid_count", int'(b0.count), 6);
    cyc(1, 1, 0, 0);
    chk("mid_rst_count", int'(b0.count), 15);
    chk("mid_rst_busy", int'(b0.busy), 0);
    cyc(0, 0, 1, 1);
    cyc(1, 1, 0, 0);
    chk("rst_cancel_tc", int'(b0.tc), 0);
    chk("rst_cancel_cnt", int'(b1.count), 15);
    cyc(0, 0, 1, 1);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0);
    chk("ar1_count", int'(b1.count), 1);
    cyc(0, 0, 0, 0);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
